ictrl_ibuffer_read_to_dma: RTL and testbench
============================================

ICTRL_IBUFFER_READ_TO_DMA -- requirements
Module: ictrl_ibuffer_read_to_dma

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 128, beat width; MEM_AW, 15, ibuffer address width; STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.
REQ-002 clk  in  1  clock; all logic SHALL be rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 dma_wr_req  in  1  start pulse; sampled only in IDLE.
REQ-005 dma_wr_base_addr  in  MEM_AW  first ibuffer address; sampled with dma_wr_req.
REQ-006 dma_wr_data_num  in  MEM_AW  beat count; sampled with dma_wr_req.
REQ-007 busy  out  1  high whenever state is not IDLE.
REQ-008 ibuffer_cen / ibuffer_wen  out  1 / 1  read request valid / write enable (SHALL be constant 0).
REQ-009 ibuffer_ready  in  1  ibuffer accepts the request in the cycle where cen&&ready.
REQ-010 ibuffer_addr  out  MEM_AW  read address.
REQ-011 ibuffer_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after each accepted request.
REQ-012 dma_wr_data_valid / dma_wr_data_ready  out / in  1 / 1  DMA write-data handshake.
REQ-013 dma_wr_data  out  DATA_WIDTH  beat data; dma_wr_strb  out  STRB_WIDTH  SHALL be all ones.
REQ-014 dma_wr_last  out  1  high with the final beat of a transfer.
REQ-015 dma_read_done  out  1  one-cycle pulse at end of transfer.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-017 IDLE->RUN on dma_wr_req with num!=0; latch base, num; clear issue counter.
REQ-018 dma_wr_req with num==0 SHALL stay IDLE and pulse dma_read_done the next cycle, no ibuffer access.
REQ-019 RUN: ibuffer_cen=1 when fifo_occupancy+inflight<3 (registered terms only; no path from dma_wr_data_ready to ibuffer_cen).
REQ-020 ibuffer_addr SHALL equal base+issue_cnt modulo 2^MEM_AW (wraps, no error).
REQ-021 Each cen&&ready SHALL increment issue_cnt, set inflight for the next cycle; cen, addr SHALL hold while ready=0.
REQ-022 RUN->DRAIN on the handshake where issue_cnt==num-1.
REQ-023 In the cycle with inflight=1, ibuffer_rdata and a last flag (set for beat num-1) SHALL be pushed into a 3-entry FIFO.
REQ-024 dma_wr_data_valid SHALL equal FIFO non-empty; dma_wr_data/dma_wr_last from FIFO head; pop on valid&&ready.
REQ-025 Push and pop in the same cycle SHALL leave occupancy unchanged; FIFO SHALL never overflow (guaranteed by REQ-019).
REQ-026 dma_wr_data, dma_wr_last SHALL stay stable while valid=1 and ready=0.
REQ-027 DRAIN->IDLE on the handshake of the last beat; dma_read_done SHALL pulse in that same cycle.
REQ-028 Latency: req in cycle 0, ready=1 throughout -> cen in cycle 1, first dma_wr_data_valid in cycle 3.
REQ-029 Throughput: ibuffer_ready and dma_wr_data_ready constantly high SHALL sustain 1 beat/cycle.
REQ-030 dma_wr_req while busy SHALL be ignored.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, counters 0, inflight 0, FIFO empty; all outputs 0 except dma_wr_strb (all ones).
REQ-032 Reset mid-transfer SHALL discard data; no done pulse; next dma_wr_req starts cleanly.

Structure
REQ-033 FSM state encoding and FIFO depth constant (3) SHALL reside in the shared ictrl package.
REQ-034 The FIFO SHALL be a sub-module ictrl_rd_data_fifo (parameterised width incl. last bit, depth 3, count output).

Verification
REQ-035 base=0, num=4, both readys high -> addr 0,1,2,3 in cycles 1-4; valid cycles 3-6; last on 4th beat; done cycle 6.
REQ-036 num=8, dma_wr_data_ready low cycles 4-10 -> at most 3 beats buffered, cen drops, no data loss/reorder, data held stable.
REQ-037 base=0x7FFE, num=4 -> addrs 0x7FFE, 0x7FFF, 0x0000, 0x0001.
REQ-038 num=0 -> no cen, done pulse next cycle, busy stays 0.
REQ-039 ibuffer_ready random 50%, num=16 -> addr held when stalled, 16 beats in order, single done.
REQ-040 rst_n low after 2 of 8 beats -> outputs zero immediately; new req num=2 completes correctly.

Source files
------------

// File: rtl/ictrl_pkg.sv
// rtl/ictrl_pkg.sv - shared ictrl types: read-to-DMA FSM states and read-data FIFO sizing
package ictrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ictrl_state_t;

    localparam int unsigned RD_FIFO_DEPTH = 3;
    localparam int unsigned RD_FIFO_CNT_W = $clog2(RD_FIFO_DEPTH + 1);

endpackage

// File: rtl/ictrl_rd_data_fifo.sv
// rtl/ictrl_rd_data_fifo.sv - small circular FIFO holding ibuffer read beats (data plus last flag)
module ictrl_rd_data_fifo
    import ictrl_pkg::*;
#(
    parameter int WIDTH = 129,
    parameter int DEPTH = RD_FIFO_DEPTH,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage is reset too so the head (and hence the DMA data bus) reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/ictrl_ibuffer_read_to_dma.sv
// rtl/ictrl_ibuffer_read_to_dma.sv - reads a block of ibuffer lines and streams them as DMA write beats
module ictrl_ibuffer_read_to_dma
    import ictrl_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int MEM_AW     = 15,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dma_wr_req,
    input  logic [MEM_AW-1:0]     dma_wr_base_addr,
    input  logic [MEM_AW-1:0]     dma_wr_data_num,
    output logic                  busy,
    output logic                  ibuffer_cen,
    output logic                  ibuffer_wen,
    input  logic                  ibuffer_ready,
    output logic [MEM_AW-1:0]     ibuffer_addr,
    input  logic [DATA_WIDTH-1:0] ibuffer_rdata,
    output logic                  dma_wr_data_valid,
    input  logic                  dma_wr_data_ready,
    output logic [DATA_WIDTH-1:0] dma_wr_data,
    output logic [STRB_WIDTH-1:0] dma_wr_strb,
    output logic                  dma_wr_last,
    output logic                  dma_read_done
);
    ictrl_state_t             state_q, state_d;
    logic [MEM_AW-1:0]        base_q, num_q, issue_cnt_q;
    logic                     inflight_q, inflight_last_q, zero_done_q;
    logic [RD_FIFO_CNT_W-1:0] fifo_cnt;
    logic [RD_FIFO_CNT_W:0]   outstanding;
    logic [DATA_WIDTH:0]      fifo_head;
    logic                     start_req, issue_fire, issue_last, beat_pop, last_pop;

    assign start_req   = (state_q == IDLE) && dma_wr_req;
    assign outstanding = {1'b0, fifo_cnt} + {{RD_FIFO_CNT_W{1'b0}}, inflight_q};
    // Only registered terms gate the read request, so downstream backpressure never reaches cen.
    assign ibuffer_cen = (state_q == RUN) && (outstanding < (RD_FIFO_CNT_W + 1)'(RD_FIFO_DEPTH));
    assign ibuffer_wen = 1'b0;
    assign ibuffer_addr = base_q + issue_cnt_q;
    assign issue_fire  = ibuffer_cen && ibuffer_ready;
    assign issue_last  = (issue_cnt_q == num_q - MEM_AW'(1));

    assign dma_wr_data_valid = (fifo_cnt != '0);
    assign dma_wr_data       = fifo_head[DATA_WIDTH-1:0];
    assign dma_wr_last       = fifo_head[DATA_WIDTH];
    assign dma_wr_strb       = '1;
    assign beat_pop          = dma_wr_data_valid && dma_wr_data_ready;
    assign last_pop          = beat_pop && dma_wr_last;
    assign dma_read_done     = zero_done_q || last_pop;
    assign busy              = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_req && (dma_wr_data_num != '0)) state_d = RUN;
            RUN:     if (issue_fire && issue_last)             state_d = DRAIN;
            DRAIN:   if (last_pop)                             state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q          <= '0;
            num_q           <= '0;
            issue_cnt_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            zero_done_q     <= 1'b0;
        end else begin
            zero_done_q     <= start_req && (dma_wr_data_num == '0);
            inflight_q      <= issue_fire;
            inflight_last_q <= issue_fire && issue_last;
            if (start_req && (dma_wr_data_num != '0)) begin
                base_q      <= dma_wr_base_addr;
                num_q       <= dma_wr_data_num;
                issue_cnt_q <= '0;
            end else if (issue_fire) begin
                issue_cnt_q <= issue_cnt_q + MEM_AW'(1);
            end
        end
    end

    ictrl_rd_data_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_data_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data ({inflight_last_q, ibuffer_rdata}),
        .pop       (beat_pop),
        .pop_data  (fifo_head),
        .count     (fifo_cnt)
    );

endmodule

// File: tb/tb_ictrl_ibuffer_read_to_dma.sv
// tb/tb_ictrl_ibuffer_read_to_dma.sv - scoreboard bench for the ibuffer-to-DMA read engine
module tb_ictrl_ibuffer_read_to_dma;
    localparam int DW = 128;
    localparam int AW = 15;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dma_wr_req;
    logic [AW-1:0] dma_wr_base_addr, dma_wr_data_num;
    logic          busy, ibuffer_cen, ibuffer_wen, ibuffer_ready;
    logic [AW-1:0] ibuffer_addr;
    logic [DW-1:0] ibuffer_rdata;
    logic          dma_wr_data_valid, dma_wr_data_ready;
    logic [DW-1:0] dma_wr_data;
    logic [SW-1:0] dma_wr_strb;
    logic          dma_wr_last, dma_read_done;

    always #5 clk = ~clk;

    ictrl_ibuffer_read_to_dma #(.DATA_WIDTH(DW), .MEM_AW(AW), .STRB_WIDTH(SW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dma_wr_req        (dma_wr_req),
        .dma_wr_base_addr  (dma_wr_base_addr),
        .dma_wr_data_num   (dma_wr_data_num),
        .busy              (busy),
        .ibuffer_cen       (ibuffer_cen),
        .ibuffer_wen       (ibuffer_wen),
        .ibuffer_ready     (ibuffer_ready),
        .ibuffer_addr      (ibuffer_addr),
        .ibuffer_rdata     (ibuffer_rdata),
        .dma_wr_data_valid (dma_wr_data_valid),
        .dma_wr_data_ready (dma_wr_data_ready),
        .dma_wr_data       (dma_wr_data),
        .dma_wr_strb       (dma_wr_strb),
        .dma_wr_last       (dma_wr_last),
        .dma_read_done     (dma_read_done)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int req_cyc = 0;
    int issued = 0;
    int popped = 0;
    int cur_num = 0;
    int ib_mode = 0;
    int dr_mode = 0;
    int stall_lo = 0;
    int stall_hi = -1;
    logic busy_seen = 1'b0;
    logic cen_drop = 1'b0;
    beat_t exp_q[$];
    int acc_log[$];
    int addr_log[$];
    int valid_log[$];
    int done_log[$];

    logic          acc_q = 1'b0;
    logic [AW-1:0] acc_addr_q = '0;
    logic          pv_stall = 1'b0, pv_last = 1'b0, pc_stall = 1'b0;
    logic [DW-1:0] pv_data = '0;
    logic [AW-1:0] pc_addr = '0;

    // Content of every ibuffer line is a fixed function of its address.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return {a, 1'b1, 16'hBEEF, ~a, 1'b0, 32'(a) * 32'h9E3779B9,
                32'(a) ^ 32'hA5A5A5A5, 16'(a) + 16'h1234};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        int rel;
        @(posedge clk);
        #1;
        cyc++;
        rel = cyc - req_cyc;
        ibuffer_rdata = acc_q ? mem_f(acc_addr_q) : {$urandom, $urandom, $urandom, $urandom};
        ibuffer_ready = (ib_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (dr_mode == 1)      dma_wr_data_ready = !(rel >= stall_lo && rel <= stall_hi);
        else if (dr_mode == 2) dma_wr_data_ready = ($urandom_range(0, 9) < 7);
        else                   dma_wr_data_ready = 1'b1;
    endtask

    task automatic start(input logic [AW-1:0] b, input logic [AW-1:0] n);
        acc_log.delete();
        addr_log.delete();
        valid_log.delete();
        done_log.delete();
        busy_seen = 1'b0;
        cen_drop  = 1'b0;
        cur_num   = int'(n);
        dma_wr_base_addr = b;
        dma_wr_data_num  = n;
        dma_wr_req       = 1'b1;
        req_cyc          = cyc;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back('{d: mem_f(AW'(int'(b) + i)), l: (i == int'(n) - 1)});
        end
        step();
        dma_wr_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        check({name, "_timeout"}, DW'(n < 3000), DW'(1));
        repeat (3) step();
        check({name, "_done_count"}, DW'(done_log.size()), DW'(1));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"},  DW'(busy), '0);
        check({name, "_cen"},   DW'(ibuffer_cen), '0);
        check({name, "_wen"},   DW'(ibuffer_wen), '0);
        check({name, "_addr"},  DW'(ibuffer_addr), '0);
        check({name, "_valid"}, DW'(dma_wr_data_valid), '0);
        check({name, "_data"},  dma_wr_data, '0);
        check({name, "_last"},  DW'(dma_wr_last), '0);
        check({name, "_done"},  DW'(dma_read_done), '0);
        check({name, "_strb"},  DW'(dma_wr_strb), DW'({SW{1'b1}}));
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Monitor: samples mid-cycle, models the ibuffer read latency and scores every DMA beat.
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            acc_q    = 1'b0;
            pv_stall = 1'b0;
            pc_stall = 1'b0;
            issued   = 0;
            popped   = 0;
        end else begin
            if (pv_stall) begin
                check("hold_data", dma_wr_data, pv_data);
                check("hold_last", DW'(dma_wr_last), DW'(pv_last));
            end
            if (pc_stall) begin
                check("hold_cen", DW'(ibuffer_cen), DW'(1));
                check("hold_addr", DW'(ibuffer_addr), DW'(pc_addr));
            end
            if (busy) begin
                busy_seen = 1'b1;
                check("outstanding_le_3", DW'((issued - popped) <= 3), DW'(1));
                if (!ibuffer_cen && acc_log.size() < cur_num) cen_drop = 1'b1;
            end
            if (ibuffer_cen) check("wen_zero", DW'(ibuffer_wen), '0);
            acc_q      = ibuffer_cen && ibuffer_ready;
            acc_addr_q = ibuffer_addr;
            if (acc_q) begin
                acc_log.push_back(cyc - req_cyc);
                addr_log.push_back(int'(ibuffer_addr));
                issued++;
            end
            if (dma_wr_data_valid) valid_log.push_back(cyc - req_cyc);
            if (dma_wr_data_valid && dma_wr_data_ready) begin
                popped++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", dma_wr_data);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", dma_wr_data, b.d);
                    check("beat_last", DW'(dma_wr_last), DW'(b.l));
                end
            end
            if (dma_read_done) begin
                done_log.push_back(cyc - req_cyc);
                check("done_after_last_beat", DW'(exp_q.size()), '0);
                check("strb_ones", DW'(dma_wr_strb), DW'({SW{1'b1}}));
            end
            pv_stall = dma_wr_data_valid && !dma_wr_data_ready;
            pv_data  = dma_wr_data;
            pv_last  = dma_wr_last;
            pc_stall = ibuffer_cen && !ibuffer_ready;
            pc_addr  = ibuffer_addr;
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        dma_wr_req = 1'b0;
        dma_wr_base_addr = '0;
        dma_wr_data_num = '0;
        ibuffer_ready = 1'b1;
        dma_wr_data_ready = 1'b1;
        ibuffer_rdata = '0;
        #2;
        check_reset_outputs("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Nominal 4-beat transfer: exact cycle timing.
        start(15'h0000, 15'd4);
        wait_idle("basic4");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic4_cen_cycle%0d", i), DW'(qget(acc_log, i)), DW'(i + 1));
            check($sformatf("basic4_addr%0d", i), DW'(qget(addr_log, i)), DW'(i));
            check($sformatf("basic4_valid_cycle%0d", i), DW'(qget(valid_log, i)), DW'(i + 3));
        end
        check("basic4_done_cycle", DW'(qget(done_log, 0)), DW'(6));

        // Backpressure window on the DMA side.
        dr_mode = 1; stall_lo = 4; stall_hi = 10;
        start(15'h0123, 15'd8);
        wait_idle("stall8");
        check("stall8_cen_dropped", DW'(cen_drop), DW'(1));
        check("stall8_issue_count", DW'(acc_log.size()), DW'(8));
        dr_mode = 0;

        // Address wrap at the top of the ibuffer.
        start(15'h7FFE, 15'd4);
        wait_idle("wrap");
        check("wrap_addr0", DW'(qget(addr_log, 0)), DW'(32'h7FFE));
        check("wrap_addr1", DW'(qget(addr_log, 1)), DW'(32'h7FFF));
        check("wrap_addr2", DW'(qget(addr_log, 2)), DW'(32'h0000));
        check("wrap_addr3", DW'(qget(addr_log, 3)), DW'(32'h0001));

        // Zero-length request.
        start(15'h0042, 15'd0);
        wait_idle("zero");
        check("zero_no_cen", DW'(acc_log.size()), '0);
        check("zero_done_cycle", DW'(qget(done_log, 0)), DW'(1));
        check("zero_busy_never", DW'(busy_seen), '0);

        // Random ibuffer stalls.
        ib_mode = 1;
        start(15'($urandom), 15'd16);
        wait_idle("ibstall16");
        check("ibstall16_issue_count", DW'(acc_log.size()), DW'(16));
        ib_mode = 0;

        // Request while busy is ignored.
        start(15'h0200, 15'd3);
        dma_wr_base_addr = 15'h5555;
        dma_wr_data_num  = 15'd5;
        dma_wr_req = 1'b1;
        step();
        dma_wr_req = 1'b0;
        wait_idle("busyreq");
        check("busyreq_issue_count", DW'(acc_log.size()), DW'(3));

        // Reset in the middle of a transfer, then a clean restart.
        start(15'h0300, 15'd8);
        n = 0;
        while (exp_q.size() > 6 && n < 100) begin
            step();
            n++;
        end
        check("midrst_reached_two_beats", DW'(exp_q.size()), DW'(6));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        step();
        step();
        check("midrst_no_done", DW'(done_log.size()), '0);
        rst_n = 1'b1;
        step();
        start(15'h0400, 15'd2);
        wait_idle("after_rst");
        check("after_rst_issue_count", DW'(acc_log.size()), DW'(2));

        // Randomised transfers with stalls on both sides.
        for (int k = 0; k < 8; k++) begin
            ib_mode = 1;
            dr_mode = 2;
            start(15'($urandom), 15'($urandom_range(1, 20)));
            wait_idle($sformatf("rand%0d", k));
            check($sformatf("rand%0d_issue_count", k), DW'(acc_log.size()), DW'(cur_num));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
